uart_tx_periph: RTL

//  Memory-mapped UART transmitter on bridge peripheral slot 3 (byteen_3 / rdata_3 / HWInt_3), beside Timer0/Timer1.

---
 rtl/uart_tx_periph.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter for bridge peripheral slot 3.
// Buffers bytes written to DATA in a DEPTH-entry FIFO and serialises them on txd
// (start bit, 8 data bits LSB first, optional even parity, stop bit).
// Register map on addr[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 DIVISOR.
// Ports:
//   clk      system clock
//   RESET_N  asynchronous active-low reset
//   byteen   slot byte enables, nonzero marks a write cycle
//   addr     bridge address (addr[3:2] decoded)
//   wdata    bridge write data
//   rdata    combinational read data for the selected register
//   IRQ      registered level interrupt (drained and idle)
//   txd      registered serial output, idle high
// Build option: define UART_TX_PARITY_EN to implement CTRL[2] par_en and the parity bit.
module uart_tx_periph #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd16
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [3:0]  byteen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        IRQ,
    output logic        txd
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           txd_q, txd_d;
    logic           irq_q, irq_d;
    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic [15:0]    div_q, div_d;

    logic           wr_en, push_req, push, pop, empty, full, busy, tx_en, bit_end;
    logic [1:0]     sel;
    logic [15:0]    reload;
    logic           unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    assign sel      = addr[3:2];
    assign wr_en    = |byteen;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign busy     = (state_q != S_IDLE);
    assign tx_en    = ctrl_q[0];
    assign push_req = wr_en && (sel == 2'd0) && byteen[0];
    assign push     = push_req && !full;
    assign bit_end  = (cnt_q == 16'd0);
    // A divisor of zero behaves as one cycle per bit.
    assign reload   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

    // Transmit sequencer: each bit held until the down-counter expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (state_q != S_IDLE && !bit_end) begin
            cnt_d = cnt_q - 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_en && !empty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    cnt_d   = reload;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = reload;
                    txd_d   = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        if (ctrl_q[2]) begin
                            state_d = S_PARITY;
                            txd_d   = ^shreg_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[3'(bit_q + 3'd1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = reload;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (tx_en && !empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping and register writes.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        irq_d    = ctrl_q[1] && tx_en && empty && !busy;
        if (push) begin
            mem_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && full) begin
            ovf_d = 1'b1;
        end else if (wr_en && sel == 2'd1) begin
            ovf_d = 1'b0;
        end
        if (wr_en && sel == 2'd2 && byteen[0]) begin
`ifdef UART_TX_PARITY_EN
            ctrl_d = wdata[2:0];
`else
            ctrl_d = {1'b0, wdata[1:0]};
`endif
        end
        if (wr_en && sel == 2'd3) begin
            if (byteen[0]) div_d[7:0]  = wdata[7:0];
            if (byteen[1]) div_d[15:8] = wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ctrl_q   <= '0;
            div_q    <= DIV_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
        end
    end

    // Side-effect-free register read.
    always_comb begin
        case (sel)
            2'd1:    rdata = {24'b0, 4'(count_q), ovf_q, empty, full, busy};
            2'd2:    rdata = {29'b0, ctrl_q};
            2'd3:    rdata = {16'b0, div_q};
            default: rdata = 32'b0;
        endcase
    end

    assign txd = txd_q;
    assign IRQ = irq_q;

endmodule
